// File: rtl/branch_compare_pkg.sv
// -----------------------------------------------------------------------------
// branch_compare_pkg
// Shared definitions for the byte-serial branch comparator:
//   state_t        FSM state encoding (IDLE / CMP / DONE)
//   F3_*           RISC-V branch funct3 encodings
//   NBYTES, IDX_W  operand width in bytes and width of the byte index
//   is_signed()    funct3 -> signed-ordering select
// -----------------------------------------------------------------------------
package branch_compare_pkg;

  localparam int NBYTES = 4;
  localparam int IDX_W  = $clog2(NBYTES);

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // BLT/BGE are the only signed branches; every other code, including the
  // unused 2 and 3, falls back to unsigned ordering.
  function automatic logic is_signed(input logic [2:0] f3);
    return (f3 == F3_BLT) || (f3 == F3_BGE);
  endfunction

endpackage

// File: rtl/branch_compare_byte_cmp.sv
// -----------------------------------------------------------------------------
// byte_cmp
// Purely combinational unsigned comparison of one byte pair.
//   a_i, b_i   8-bit operands
//   lt_o       a_i <  b_i
//   eq_o       a_i == b_i
//   gt_o       a_i >  b_i
// -----------------------------------------------------------------------------
module byte_cmp (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic       lt_o,
  output logic       eq_o,
  output logic       gt_o
);

  assign lt_o = (a_i <  b_i);
  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/branch_compare.sv
// -----------------------------------------------------------------------------
// branch_compare
// Byte-serial 32-bit branch comparator. Operands are latched on the accepting
// edge and compared one byte per cycle, most significant byte first, stopping
// at the first differing byte. Signed ordering is obtained by flipping the
// sign bit of both operands and then comparing unsigned.
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     compare request, accepted only in IDLE
//   funct3    branch funct3, selects signed (4,5) / unsigned (others) order
//   rs1, rs2  32-bit operands, sampled on the accepting edge only
//   busy      high while bytes are being compared
//   done      one-cycle pulse when lt/eq/gt have been updated
//   lt/eq/gt  registered result of the last completed compare
// -----------------------------------------------------------------------------
module branch_compare
  import branch_compare_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic        lt,
  output logic        eq,
  output logic        gt
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [31:0]        a_q,     a_d;
  logic [31:0]        b_q,     b_d;
  logic               lt_q,    lt_d;
  logic               eq_q,    eq_d;
  logic               gt_q,    gt_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic [7:0]         a_byte, b_byte;
  logic               byte_lt, byte_eq, byte_gt;
  logic               sgn;

  assign sgn = is_signed(funct3);

  // Single comparator shared across all four byte positions.
  assign a_byte = a_q[{idx_q, 3'b000} +: 8];
  assign b_byte = b_q[{idx_q, 3'b000} +: 8];

  byte_cmp u_byte_cmp (
    .a_i  (a_byte),
    .b_i  (b_byte),
    .lt_o (byte_lt),
    .eq_o (byte_eq),
    .gt_o (byte_gt)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned -- that is what keeps this block from inferring latches.
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = {rs1[31] ^ sgn, rs1[30:0]};
          b_d     = {rs2[31] ^ sgn, rs2[30:0]};
          idx_d   = IDX_W'(NBYTES - 1);
          state_d = CMP;
        end
      end
      CMP: begin
        if (!byte_eq) begin
          lt_d    = byte_lt;
          gt_d    = byte_gt;
          eq_d    = 1'b0;
          state_d = DONE;
        end else if (idx_q == '0) begin
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // busy/done are registered copies of the next state so the outputs come
    // straight from flops.
    busy_d = (state_d == CMP);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of statement order.
    if (rst) begin
      // NOTE: the operand registers are plain flops, not a memory array, so
      // clearing them here costs nothing and makes post-reset state fully known.
      state_q <= IDLE;
      idx_q   <= IDX_W'(NBYTES - 1);
      a_q     <= '0;
      b_q     <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lt   = lt_q;
  assign eq   = eq_q;
  assign gt   = gt_q;

endmodule
